// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
// if_fetch_unit_pkg
// Shared pipeline package for the fetch stage and its neighbours.
// Contents:
//   fetch_state_t    - fetch sequencer states (IDLE, RUN, HOLD, HOLD_PEND)
//   DEFAULT_RESET_PC - address of the first fetch after reset
//   PC_INC           - byte distance between sequential instruction words
// ============================================================================
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        HOLD      = 2'd2,
        HOLD_PEND = 2'd3
    } fetch_state_t;

    localparam int unsigned DEFAULT_RESET_PC = 0;
    localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/if_fetch_unit_npc_select.sv
// ============================================================================
// npc_select
// Combinational next-nPC selection for the fetch unit.
// Ports:
//   i_npc             - current nPC register
//   i_redirect        - branch/jump taken this cycle
//   i_redirect_target - raw byte target from decode
//   i_pend            - a redirect taken during a stall is still waiting
//   i_pend_target     - word-aligned target captured during the stall
//   o_target_aligned  - i_redirect_target with bits [1:0] cleared
//   o_next_npc        - value nPC takes on the next advance
// ============================================================================
module npc_select
    import if_fetch_unit_pkg::*;
#(
    parameter int PC_W = 9
) (
    input  logic [PC_W-1:0] i_npc,
    input  logic            i_redirect,
    input  logic [PC_W-1:0] i_redirect_target,
    input  logic            i_pend,
    input  logic [PC_W-1:0] i_pend_target,
    output logic [PC_W-1:0] o_target_aligned,
    output logic [PC_W-1:0] o_next_npc
);

    logic [PC_W-1:0] w_seq_npc;

    assign o_target_aligned = {i_redirect_target[PC_W-1:2], 2'b00};

    // Sequential successor; the sum wraps naturally at PC_W bits.
    assign w_seq_npc = i_npc + PC_W'(PC_INC);

    // A redirect arriving on the advance cycle is newer than any stalled one.
    always_comb begin
        o_next_npc = w_seq_npc;
        if (i_redirect) begin
            o_next_npc = o_target_aligned;
        end else if (i_pend) begin
            o_next_npc = i_pend_target;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit
// Instruction fetch stage with a PC/nPC pair giving one branch delay slot.
// Redirects arriving while the stage is stalled are remembered (newest wins)
// and applied on the next advance.
// Ports:
//   clk, reset        - clock; synchronous active-low reset
//   le                - advance enable shared with the IF/ID register
//   redirect          - one-cycle branch/jump taken pulse from decode
//   redirect_target   - byte target address (low two bits ignored)
//   imem_addr         - instruction memory address (= PC)
//   imem_data         - combinational instruction memory read data
//   instruction_in_o  - fetched word, 0 when the fetch is not valid
//   pc_o, npc_o       - PC of the presented word and the next PC
//   fetch_valid       - presented word is a real fetch
//   fetch_count       - saturating count of PC advances
// ============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int          PC_W     = 9,
    parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            le,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    output logic [31:0]     instruction_in_o,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] npc_o,
    output logic            fetch_valid,
    output logic [15:0]     fetch_count
);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_npc;
    logic [PC_W-1:0] r_pend_target;
    logic [15:0]     r_fetch_count;
    logic            r_fetch_valid;

    logic            w_pend;
    logic [PC_W-1:0] w_target_aligned;
    logic [PC_W-1:0] w_next_npc;

    // The pending flag is exactly the HOLD_PEND state, so no separate register.
    assign w_pend = (r_state == HOLD_PEND);

    npc_select #(
        .PC_W (PC_W)
    ) u_npc_select (
        .i_npc             (r_npc),
        .i_redirect        (redirect),
        .i_redirect_target (redirect_target),
        .i_pend            (w_pend),
        .i_pend_target     (r_pend_target),
        .o_target_aligned  (w_target_aligned),
        .o_next_npc        (w_next_npc)
    );

    // Fetch sequencer. IDLE spends one cycle after reset presenting nothing;
    // every later state advances PC on le=1, and a stalled redirect parks its
    // target in r_pend_target until the stall releases.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_pc          <= PC_W'(RESET_PC);
            r_npc         <= PC_W'(RESET_PC + PC_INC);
            r_pend_target <= '0;
            r_fetch_count <= '0;
            r_fetch_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state       <= RUN;
                    r_fetch_valid <= 1'b1;
                end
                RUN, HOLD, HOLD_PEND: begin
                    r_fetch_valid <= 1'b1;
                    if (le) begin
                        r_pc          <= r_npc;
                        r_npc         <= w_next_npc;
                        r_pend_target <= '0;
                        r_state       <= RUN;
                        if (r_fetch_count != 16'hFFFF) begin
                            r_fetch_count <= r_fetch_count + 16'd1;
                        end
                    end else if (redirect) begin
                        r_pend_target <= w_target_aligned;
                        r_state       <= HOLD_PEND;
                    end else if (r_state == RUN) begin
                        r_state <= HOLD;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr        = r_pc;
    assign pc_o             = r_pc;
    assign npc_o            = r_npc;
    assign fetch_valid      = r_fetch_valid;
    assign fetch_count      = r_fetch_count;
    assign instruction_in_o = r_fetch_valid ? imem_data : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit
// Directed bench for if_fetch_unit with a behavioural fetch model and
// literal spot checks along the way.
// ============================================================================
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        le;
    logic        redirect;
    logic [8:0]  redirect_target;
    logic [8:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instruction_in_o;
    logic [8:0]  pc_o;
    logic [8:0]  npc_o;
    logic        fetch_valid;
    logic [15:0] fetch_count;

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    // Behavioural view: addresses of the presented and next word, whether a
    // word is presented at all, any stalled redirect target, advance count.
    logic [8:0]  modelPc;
    logic [8:0]  modelNpc;
    bit          modelLive;
    logic [8:0]  pendQ[$];
    logic [15:0] modelCount;

    if_fetch_unit #(
        .PC_W     (9),
        .RESET_PC (0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .le               (le),
        .redirect         (redirect),
        .redirect_target  (redirect_target),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .instruction_in_o (instruction_in_o),
        .pc_o             (pc_o),
        .npc_o            (npc_o),
        .fetch_valid      (fetch_valid),
        .fetch_count      (fetch_count)
    );

    // Instruction memory: each word encodes its own address.
    assign imem_data = 32'hA500_0000 | {23'd0, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Model step on every edge, then compare all outputs 1 ns later.
    always @(posedge clk) begin
        if (!reset) begin
            modelPc    = 9'h000;
            modelNpc   = 9'h004;
            modelLive  = 1'b0;
            pendQ.delete();
            modelCount = 16'h0000;
        end else if (!modelLive) begin
            modelLive = 1'b1;
        end else if (le) begin
            logic [8:0] nextNpc;
            if (redirect)
                nextNpc = redirect_target & 9'h1FC;
            else if (pendQ.size() != 0)
                nextNpc = pendQ[0];
            else
                nextNpc = modelNpc + 9'd4;
            modelPc  = modelNpc;
            modelNpc = nextNpc;
            pendQ.delete();
            if (modelCount != 16'hFFFF) modelCount = modelCount + 16'd1;
        end else if (redirect) begin
            pendQ.delete();
            pendQ.push_back(redirect_target & 9'h1FC);
        end
        #1;
        if (checkEn) begin
            checkOutput("model_pc",    {23'd0, pc_o},        {23'd0, modelPc});
            checkOutput("model_npc",   {23'd0, npc_o},       {23'd0, modelNpc});
            checkOutput("model_addr",  {23'd0, imem_addr},   {23'd0, modelPc});
            checkOutput("model_valid", {31'd0, fetch_valid}, {31'd0, modelLive});
            checkOutput("model_instr", instruction_in_o,
                        modelLive ? (32'hA500_0000 | {23'd0, modelPc}) : 32'd0);
            checkOutput("model_count", {16'd0, fetch_count}, {16'd0, modelCount});
        end
    end

    task automatic applyStimulus(input logic iLe, input logic iRedirect,
                                 input logic [8:0] iTarget, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            le              = iLe;
            redirect        = iRedirect;
            redirect_target = iTarget;
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        reset           = 1'b0;
        le              = 1'b1;
        redirect        = 1'b0;
        redirect_target = 9'h000;

        repeat (2) @(posedge clk);
        #2;
        checkEn = 1'b1;
        checkOutput("rst_pc",    {23'd0, pc_o},        32'h0);
        checkOutput("rst_npc",   {23'd0, npc_o},       32'h4);
        checkOutput("rst_valid", {31'd0, fetch_valid}, 32'h0);
        checkOutput("rst_instr", instruction_in_o,     32'h0);
        checkOutput("rst_count", {16'd0, fetch_count}, 32'h0);

        // Release reset: IDLE cycle, then first real fetch at address 0.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("run_pc0",    {23'd0, pc_o},        32'h0);
        checkOutput("run_valid",  {31'd0, fetch_valid}, 32'h1);
        applyStimulus(1'b1, 1'b0, 9'h000, 1);
        checkOutput("seq_pc4",    {23'd0, pc_o},        32'h4);
        applyStimulus(1'b1, 1'b0, 9'h000, 1);
        checkOutput("seq_pc8",    {23'd0, pc_o},        32'h8);
        applyStimulus(1'b1, 1'b0, 9'h000, 1);
        checkOutput("seq_pcC",    {23'd0, pc_o},        32'hC);
        applyStimulus(1'b1, 1'b0, 9'h000, 1);
        checkOutput("seq_pc10",   {23'd0, pc_o},        32'h10);
        checkOutput("seq_count4", {16'd0, fetch_count}, 32'h4);

        // Taken branch at 0x10: delay slot 0x14, then 0x40, 0x44.
        applyStimulus(1'b1, 1'b1, 9'h040, 1);
        checkOutput("br_slot",    {23'd0, pc_o},        32'h14);
        applyStimulus(1'b1, 1'b0, 9'h000, 1);
        checkOutput("br_tgt",     {23'd0, pc_o},        32'h40);
        applyStimulus(1'b1, 1'b0, 9'h000, 1);
        checkOutput("br_tgt4",    {23'd0, pc_o},        32'h44);

        // Stall with two redirects; newest target wins after release.
        applyStimulus(1'b0, 1'b0, 9'h000, 1);
        applyStimulus(1'b0, 1'b1, 9'h080, 1);
        applyStimulus(1'b0, 1'b1, 9'h0A0, 1);
        checkOutput("hold_pc",    {23'd0, pc_o},        32'h44);
        checkOutput("hold_npc",   {23'd0, npc_o},       32'h48);
        checkOutput("hold_instr", instruction_in_o,     32'hA500_0044);
        applyStimulus(1'b1, 1'b0, 9'h000, 1);
        checkOutput("rel_pc",     {23'd0, pc_o},        32'h48);
        checkOutput("rel_npc",    {23'd0, npc_o},       32'hA0);
        applyStimulus(1'b1, 1'b0, 9'h000, 1);
        checkOutput("rel_tgt",    {23'd0, pc_o},        32'hA0);

        // Stalled redirect superseded by a redirect on the release cycle.
        applyStimulus(1'b0, 1'b1, 9'h100, 1);
        applyStimulus(1'b1, 1'b1, 9'h0C8, 1);
        checkOutput("sup_pc",     {23'd0, pc_o},        32'hA4);
        checkOutput("sup_npc",    {23'd0, npc_o},       32'hC8);
        applyStimulus(1'b1, 1'b0, 9'h000, 1);
        checkOutput("sup_tgt",    {23'd0, pc_o},        32'hC8);

        // Wrap at 9 bits and target alignment.
        applyStimulus(1'b1, 1'b1, 9'h1F8, 1);
        applyStimulus(1'b1, 1'b0, 9'h000, 1);
        checkOutput("wrap_1f8",   {23'd0, pc_o},        32'h1F8);
        applyStimulus(1'b1, 1'b0, 9'h000, 1);
        checkOutput("wrap_1fc",   {23'd0, pc_o},        32'h1FC);
        applyStimulus(1'b1, 1'b0, 9'h000, 1);
        checkOutput("wrap_000",   {23'd0, pc_o},        32'h000);
        applyStimulus(1'b1, 1'b1, 9'h043, 1);
        checkOutput("align_npc",  {23'd0, npc_o},       32'h040);
        applyStimulus(1'b1, 1'b0, 9'h000, 1);
        checkOutput("align_pc",   {23'd0, pc_o},        32'h040);

        // Reset while a redirect is pending: the target is dropped.
        applyStimulus(1'b0, 1'b1, 9'h120, 1);
        @(negedge clk);
        reset = 1'b0;
        le    = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("prst_pc",    {23'd0, pc_o},        32'h0);
        checkOutput("prst_npc",   {23'd0, npc_o},       32'h4);
        checkOutput("prst_count", {16'd0, fetch_count}, 32'h0);
        @(negedge clk);
        reset    = 1'b1;
        redirect = 1'b0;
        @(posedge clk);
        #2;
        applyStimulus(1'b1, 1'b0, 9'h000, 2);
        checkOutput("prst_pc8",   {23'd0, pc_o},        32'h8);
        checkOutput("prst_npcC",  {23'd0, npc_o},       32'hC);

        // Counter saturation.
        @(negedge clk);
        le = 1'b0;
        force dut.r_fetch_count = 16'hFFFE;
        modelCount = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.r_fetch_count;
        applyStimulus(1'b1, 1'b0, 9'h000, 1);
        checkOutput("sat_ffff",   {16'd0, fetch_count}, 32'hFFFF);
        applyStimulus(1'b1, 1'b0, 9'h000, 2);
        checkOutput("sat_hold",   {16'd0, fetch_count}, 32'hFFFF);

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
